md_scheduler: RTL and testbench

//  Sequences the multi-cycle multiply/divide resource and HI/LO registers of the pipelined MIPS core.
//  - Accepts MD ops from the E stage.
//  - Runs a fixed-latency busy counter per op class.
//  - Commits results to HI/LO and serves MFHI/MFLO reads.
//  - Raises a stall request that holds a D-stage MD instruction while the unit is occupied.
//  - Sits beside the E-stage ALU. Its stall output feeds the pipeline hazard logic.

---
 rtl/md_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_md_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/md_scheduler.sv
// Multiply/divide sequencer for the pipelined MIPS core: owns HI/LO, times each
// MD op with a fixed-latency busy counter and asks the hazard logic to stall D-stage MD ops.
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_is_md,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_r;
  logic [CW-1:0]   count_r;
  logic            busy_r;
  logic [31:0]     hi_r;
  logic [31:0]     lo_r;
  logic [31:0]     rs_r;
  logic [31:0]     rt_r;
  logic [3:0]      op_r;

  logic            start_op_s;
  logic            is_mult_s;
  logic [63:0]     smul_s;
  logic [63:0]     umul_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic            div_nz_s;
  logic [31:0]     a_mag_s;
  logic [31:0]     b_mag_s;
  logic [31:0]     divisor_s;
  logic [31:0]     sq_s;
  logic [31:0]     sr_s;
  logic [31:0]     uq_s;
  logic [31:0]     ur_s;
  logic            res_we_s;
  logic [31:0]     res_hi_s;
  logic [31:0]     res_lo_s;

  // Classify the E-stage op: which ops occupy the unit and which latency class they use
  always_comb begin
    start_op_s = 1'b0;
    is_mult_s  = 1'b0;
    case (e_md_op)
      OP_MULT, OP_MULTU: begin
        start_op_s = 1'b1;
        is_mult_s  = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        start_op_s = 1'b1;
        is_mult_s  = 1'b0;
      end
      default: begin
        start_op_s = 1'b0;
        is_mult_s  = 1'b0;
      end
    endcase
  end

  assign start    = e_valid & start_op_s & ~busy_r;
  assign stall_md = d_is_md & (busy_r | start);
  assign busy     = busy_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

  // Serve MFHI/MFLO directly from the architected registers
  always_comb begin
    md_out = 32'h0000_0000;
    case (e_md_op)
      OP_MFHI: md_out = hi_r;
      OP_MFLO: md_out = lo_r;
      default: md_out = 32'h0000_0000;
    endcase
  end

  // Result datapath from the latched operands, consumed only on the completion edge
  always_comb begin
    smul_s    = {{32{rs_r[31]}}, rs_r} * {{32{rt_r[31]}}, rt_r};
    umul_s    = {32'h0000_0000, rs_r} * {32'h0000_0000, rt_r};
    a_neg_s   = rs_r[31];
    b_neg_s   = rt_r[31];
    div_nz_s  = (rt_r != 32'h0000_0000);
    a_mag_s   = a_neg_s ? (32'h0000_0000 - rs_r) : rs_r;
    b_mag_s   = b_neg_s ? (32'h0000_0000 - rt_r) : rt_r;
    // Divide on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN with zero remainder
    divisor_s = div_nz_s ? b_mag_s : 32'h0000_0001;
    sq_s      = a_mag_s / divisor_s;
    sr_s      = a_mag_s % divisor_s;
    uq_s      = rs_r / (div_nz_s ? rt_r : 32'h0000_0001);
    ur_s      = rs_r % (div_nz_s ? rt_r : 32'h0000_0001);
    res_we_s  = 1'b0;
    res_hi_s  = hi_r;
    res_lo_s  = lo_r;
    case (op_r)
      OP_MULT: begin
        res_we_s = 1'b1;
        res_hi_s = smul_s[63:32];
        res_lo_s = smul_s[31:0];
      end
      OP_MULTU: begin
        res_we_s = 1'b1;
        res_hi_s = umul_s[63:32];
        res_lo_s = umul_s[31:0];
      end
      OP_DIV: begin
        res_we_s = div_nz_s;
        res_lo_s = (a_neg_s ^ b_neg_s) ? (32'h0000_0000 - sq_s) : sq_s;
        res_hi_s = a_neg_s ? (32'h0000_0000 - sr_s) : sr_s;
      end
      OP_DIVU: begin
        res_we_s = div_nz_s;
        res_lo_s = uq_s;
        res_hi_s = ur_s;
      end
      default: begin
        res_we_s = 1'b0;
        res_hi_s = hi_r;
        res_lo_s = lo_r;
      end
    endcase
  end

  // Control FSM: IDLE accepts ops and MTHI/MTLO, RUN counts down and commits on the last cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      count_r <= '0;
      busy_r  <= 1'b0;
      hi_r    <= 32'h0000_0000;
      lo_r    <= 32'h0000_0000;
      rs_r    <= 32'h0000_0000;
      rt_r    <= 32'h0000_0000;
      op_r    <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r    <= e_md_op;
            rs_r    <= e_rs;
            rt_r    <= e_rt;
            count_r <= is_mult_s ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else if (e_valid && (e_md_op == OP_MTHI)) begin
            hi_r <= e_rs;
          end else if (e_valid && (e_md_op == OP_MTLO)) begin
            lo_r <= e_rs;
          end
        end
        RUN: begin
          if (count_r > CW'(1)) begin
            count_r <= count_r - CW'(1);
          end else begin
            if (res_we_s) begin
              hi_r <= res_hi_s;
              lo_r <= res_lo_s;
            end
            count_r <= '0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          count_r <= '0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler: expected HI/LO pairs are queued when an op is
// issued and compared when busy falls; control outputs are checked cycle by cycle.
module tb_md_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_md_op;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        d_is_md;
  logic        start;
  logic        busy;
  logic        stall_md;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .e_valid  (e_valid),
    .e_md_op  (e_md_op),
    .e_rs     (e_rs),
    .e_rt     (e_rt),
    .d_is_md  (d_is_md),
    .start    (start),
    .busy     (busy),
    .stall_md (stall_md),
    .md_out   (md_out),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Hard stop in case anything wedges
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    e_valid = 1'b0;
    e_md_op = 4'd0;
    e_rs    = 32'h0000_0000;
    e_rt    = 32'h0000_0000;
  endtask

  // Issue one MD op, count busy cycles, then pop and compare the committed HI/LO
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input int n, input logic [63:0] exp,
                        input int inject_at);
    int          cyc;
    logic [63:0] want;
    e_valid = 1'b1;
    e_md_op = op;
    e_rs    = rs;
    e_rt    = rt;
    #1;
    chk({tag, ".start"}, {63'd0, start}, 64'd1);
    if (d_is_md) chk({tag, ".stall_start"}, {63'd0, stall_md}, 64'd1);
    sb_q.push_back(exp);
    tick();
    idle_inputs();
    cyc = 0;
    while (busy === 1'b1 && cyc < 64) begin
      cyc++;
      if (d_is_md) chk({tag, ".stall_busy"}, {63'd0, stall_md}, 64'd1);
      if (cyc == inject_at) begin
        e_valid = 1'b1;
        e_md_op = 4'd1;
        e_rs    = 32'h0000_0007;
        e_rt    = 32'h0000_0009;
        #1;
        chk({tag, ".restart_blocked"}, {63'd0, start}, 64'd0);
      end
      tick();
      idle_inputs();
    end
    chk({tag, ".busy_cycles"}, 64'(cyc), 64'(n));
    if (d_is_md) chk({tag, ".stall_after"}, {63'd0, stall_md}, 64'd0);
    want = sb_q.pop_front();
    chk({tag, ".hilo"}, {hi, lo}, want);
    m_hi = want[63:32];
    m_lo = want[31:0];
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    idle_inputs();
    d_is_md = 1'b0;
    reset   = 1'b1;
    m_hi    = 32'h0000_0000;
    m_lo    = 32'h0000_0000;

    // 1 reset
    tick();
    tick();
    reset   = 1'b0;
    d_is_md = 1'b1;
    #1;
    chk("reset.hilo",   {hi, lo}, 64'h0);
    chk("reset.busy",   {63'd0, busy}, 64'd0);
    chk("reset.stall",  {63'd0, stall_md}, 64'd0);
    chk("reset.md_out", {32'h0, md_out}, 64'h0);
    d_is_md = 1'b0;
    tick();

    // 2 multiply
    run_op("mult",  4'd1, 32'hFFFF_FFFE, 32'h0000_0003, 5, 64'hFFFF_FFFF_FFFF_FFFA, 0);
    run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'h0000_0003, 5, 64'h0000_0002_FFFF_FFFA, 0);
    ra = $urandom;
    rb = $urandom;
    run_op("multu_rnd", 4'd2, ra, rb, 5, {32'h0, ra} * {32'h0, rb}, 0);

    // 3 divide
    run_op("div",       4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 10, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("divu_zero", 4'd4, 32'h0000_0007, 32'h0000_0000, 10, {m_hi, m_lo}, 0);
    run_op("div_ovf",   4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 64'h0000_0000_8000_0000, 0);
    run_op("div_negb",  4'd3, 32'h0000_0007, 32'hFFFF_FFFE, 10, 64'h0000_0001_FFFF_FFFD, 0);
    run_op("div_zero",  4'd3, 32'hFFFF_FFF9, 32'h0000_0000, 10, {m_hi, m_lo}, 0);
    ra = $urandom;
    rb = 32'($urandom_range(1, 1000));
    run_op("divu_rnd",  4'd4, ra, rb, 10, {ra % rb, ra / rb}, 0);

    // 4 stall with a blocked restart mid-run
    d_is_md = 1'b1;
    run_op("div_stall", 4'd3, 32'd100, 32'd7, 10, 64'h0000_0002_0000_000E, 3);
    d_is_md = 1'b0;

    // 5 MTHI/MTLO and MF reads
    e_valid = 1'b1;
    e_md_op = 4'd5;
    e_rs    = 32'h1234_5678;
    tick();
    m_hi    = 32'h1234_5678;
    e_md_op = 4'd7;
    e_rs    = 32'h0000_0000;
    #1;
    chk("mfhi", {32'h0, md_out}, {32'h0, m_hi});
    e_md_op = 4'd8;
    #1;
    chk("mflo", {32'h0, md_out}, {32'h0, m_lo});
    e_md_op = 4'd6;
    e_rs    = 32'hCAFE_F00D;
    tick();
    m_lo    = 32'hCAFE_F00D;
    e_md_op = 4'd8;
    #1;
    chk("mtlo_mflo", {32'h0, md_out}, {32'h0, m_lo});
    e_valid = 1'b0;
    e_md_op = 4'd5;
    e_rs    = 32'hDEAD_BEEF;
    tick();
    chk("mthi_bubble", {hi, lo}, {m_hi, m_lo});
    e_md_op = 4'd0;
    #1;
    chk("none_md_out", {32'h0, md_out}, 64'h0);
    idle_inputs();

    // 6 reset mid-operation
    e_valid = 1'b1;
    e_md_op = 4'd1;
    e_rs    = 32'h0000_0005;
    e_rt    = 32'h0000_0006;
    tick();
    idle_inputs();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid.busy", {63'd0, busy}, 64'd0);
    chk("rst_mid.hilo", {hi, lo}, 64'h0);
    for (int i = 0; i < 8; i++) tick();
    chk("rst_mid.late", {hi, lo, 1'b0} >> 1, 64'h0);
    chk("rst_mid.busy_late", {63'd0, busy}, 64'd0);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
